alu_ctrl_unit: RTL and testbench
================================

# alu_ctrl_unit

Sequential ALU control issuer that sits between the instruction decode stage and the datapath ALU and produces the 3-bit ALU control code consumed there. Accepts decoded ALUOp/funct fields over a valid/ready handshake, translates them into the ALU operation code, and presents the code with a one-cycle completion strobe. Multiply operations are held for a configurable number of cycles, and the upstream stage is stalled through `ready_o` for that time.

## Interface
- `MUL_LAT`, default 3: cycles from MUL acceptance to `valid_o`; legal range 1..15.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `valid_i` input 1: decode presents an operation.
- `ready_o` output 1: unit can accept an operation this cycle.
- `ALUOp_i` input 2: operation class from main control.
- `funct_i` input 10: {funct7[6:0], funct3[2:0]}.
- `flush_i` input 1: synchronous abort of any pending operation.
- `ALUCtrl_o` output 3: ALU control code, registered.
- `valid_o` output 1: one-cycle strobe; `ALUCtrl_o` is final for this operation.
- `illegal_o` output 1: one-cycle strobe alongside `valid_o` when the encoding was undecodable.

## Operation
- ALU codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111, MUL=011.
- Decode by `ALUOp_i`:
  - 00: ADD, used by loads and stores.
  - 01: SUB, used by branches.
  - 10 (R-type), by funct7/funct3:
    - 0000000/111: AND.
    - 0000000/110: OR.
    - 0000000/000: ADD.
    - 0100000/000: SUB.
    - 0000000/010: SLT.
    - 0000001/000: MUL.
  - 11 (I-type): funct3=000 gives ADD, and funct7 is ignored.
- Any other combination is illegal. The unit issues ADD (010) with `illegal_o`=1 on the same cycle `valid_o` is high.
- Acceptance occurs at a rising edge with `valid_i`=1, `ready_o`=1 and `flush_i`=0.
- States:
  - IDLE: `ready_o`=1.
  - MULWAIT: `ready_o`=0, and a 4-bit down-counter `cnt` is running.
- IDLE, non-MUL accept:
  - `ALUCtrl_o` is loaded with the decoded code.
  - `valid_o`=1 for the next cycle.
  - The unit stays in IDLE.
- IDLE, MUL accept:
  - `ALUCtrl_o`=011.
  - If `MUL_LAT`=1, behaves exactly as a non-MUL accept.
  - Otherwise `cnt` is loaded with `MUL_LAT`-2 and the unit goes to MULWAIT.
- MULWAIT:
  - `cnt` decrements each cycle.
  - At the edge where `cnt`=0, the unit returns to IDLE and sets `valid_o`=1.
  - `valid_i` is ignored throughout MULWAIT.
- `flush_i`=1 at an edge:
  - state goes to IDLE, `cnt` to 0, `valid_o` to 0 and `illegal_o` to 0.
  - `ALUCtrl_o` holds its value.
  - Flush has priority over a simultaneous accept or MUL completion: that operation is dropped and no `valid_o` is produced.
- `ALUCtrl_o` holds its last value between operations.
- `valid_o` and `illegal_o` are pulses, cleared on every edge that does not set them.

## Timing
- Reset values:
  - `ALUCtrl_o`=010 (ADD).
  - `valid_o`=0, `illegal_o`=0.
  - `ready_o`=1, state IDLE, `cnt`=0.
- Reset mid-MULWAIT discards the operation immediately; no `valid_o` after release.
- Non-MUL latency: accept at edge N gives `valid_o` high in cycle N+1. Back-to-back accepts produce one result per cycle.
- MUL latency: accept at edge N gives `valid_o` high in the cycle following edge N+`MUL_LAT`-1, and `ready_o`=0 from edge N until that same edge.
- `ready_o` is high in the cycle `valid_o` is high after a MUL, so a new operation can be accepted with zero bubbles.
- `ready_o` is a pure function of state, with no combinational path from `valid_i`.

## Configuration
- `ALU_CTRL_MUL_EN` defined:
  - MUL decode, the MULWAIT state and `cnt` are present.
  - `MUL_LAT` is honoured.
- `ALU_CTRL_MUL_EN` undefined:
  - funct7=0000001/000 is illegal, producing ADD with `illegal_o`=1.
  - MULWAIT and `cnt` are removed and `ready_o` is tied to 1.
  - `MUL_LAT` is ignored.

## Test plan
- Reset: assert `rst_i`=0 asynchronously, mid-cycle → `ALUCtrl_o`=010, `valid_o`=0 and `ready_o`=1 before the next clock edge.
- R-type sweep, back-to-back: ALUOp=10 with funct 0000000/111, 0000000/110, 0100000/000, 0000000/010 on consecutive cycles → `ALUCtrl_o`=000, 001, 110, 111 on consecutive cycles, `valid_o` high on each.
- Illegal encodings: ALUOp=10, funct=0100000/111, then ALUOp=11, funct3=001 → `ALUCtrl_o`=010 with `valid_o`=1 and `illegal_o`=1 on both.
- MUL latency with `MUL_LAT`=3 and `ALU_CTRL_MUL_EN` defined: accept MUL at edge 0, hold `valid_i`=1 with ADD pending → `ready_o`=0 in cycles 1–2, `valid_o` in cycle 3, ADD accepted at edge 3, `ALUCtrl_o`=010 with `valid_o` in cycle 4.
- Flush: MUL accepted with `MUL_LAT`=4, `flush_i`=1 at edge 2 → no `valid_o` at any point, `ready_o`=1 from cycle 3, `ALUCtrl_o` stays 011.
- Config off, `ALU_CTRL_MUL_EN` undefined: MUL encoding → `valid_o` in the next cycle with `ALUCtrl_o`=010 and `illegal_o`=1, `ready_o` never low.

Source files
------------

// File: rtl/alu_ctrl_unit_if.sv
// alu_ctrl_unit_if: decode-to-ALU-control handshake bundle.
// Signals:
//   valid_i    decode presents an operation
//   ready_o    unit can accept an operation this cycle
//   ALUOp_i    operation class from main control
//   funct_i    {funct7[6:0], funct3[2:0]}
//   flush_i    synchronous abort of any pending operation
//   ALUCtrl_o  registered ALU control code
//   valid_o    one-cycle strobe, ALUCtrl_o final for this operation
//   illegal_o  one-cycle strobe alongside valid_o for undecodable encodings
interface alu_ctrl_unit_if;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] ALUOp_i;
    logic [9:0] funct_i;
    logic       flush_i;
    logic [2:0] ALUCtrl_o;
    logic       valid_o;
    logic       illegal_o;
    modport master (
        output valid_i, ALUOp_i, funct_i, flush_i,
        input  ready_o, ALUCtrl_o, valid_o, illegal_o
    );
    modport slave (
        input  valid_i, ALUOp_i, funct_i, flush_i,
        output ready_o, ALUCtrl_o, valid_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: translates decoded ALUOp/funct into the 3-bit ALU control code.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   bus    alu_ctrl_unit_if.slave (valid/ready handshake, flush, code and strobes)
// Parameter MUL_LAT (1..15): cycles from MUL acceptance to valid_o.
// Macro ALU_CTRL_MUL_EN: when defined, MUL decode and the multi-cycle MULWAIT
// stall are built; otherwise MUL encodings are illegal and ready_o is tied high.
module alu_ctrl_unit #(
    parameter int unsigned MUL_LAT = 3
) (
    input logic            clk_i,
    input logic            rst_i,
    alu_ctrl_unit_if.slave bus
);
    localparam logic [2:0] AND_C = 3'b000;
    localparam logic [2:0] OR_C  = 3'b001;
    localparam logic [2:0] ADD_C = 3'b010;
    localparam logic [2:0] SUB_C = 3'b110;
    localparam logic [2:0] SLT_C = 3'b111;
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
        $error("alu_ctrl_unit: MUL_LAT must be 1..15");
    end
    logic [6:0] f7;
    logic [2:0] f3;
    logic [2:0] code;
    logic       illegal;
    logic       ready;
    logic       accept;
    logic [2:0] ctrl_q, ctrl_d;
    logic       valid_q, valid_d;
    logic       illegal_q, illegal_d;
    assign f7 = bus.funct_i[9:3];
    assign f3 = bus.funct_i[2:0];
`ifdef ALU_CTRL_MUL_EN
    localparam logic [2:0] MUL_C = 3'b011;
    typedef enum logic {IDLE, MULWAIT} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       is_mul;
    assign is_mul = bus.ALUOp_i == 2'b10 && f7 == 7'b0000001 && f3 == 3'b000;
    assign ready  = state_q == IDLE;
`else
    assign ready = 1'b1;
`endif
    assign accept = bus.valid_i && ready && !bus.flush_i;
    always_comb begin
        code    = ADD_C;
        illegal = 1'b0;
        case (bus.ALUOp_i)
            2'b00: code = ADD_C;
            2'b01: code = SUB_C;
            2'b10: begin
                if (f7 == 7'b0000000 && f3 == 3'b111) code = AND_C;
                else if (f7 == 7'b0000000 && f3 == 3'b110) code = OR_C;
                else if (f7 == 7'b0000000 && f3 == 3'b000) code = ADD_C;
                else if (f7 == 7'b0100000 && f3 == 3'b000) code = SUB_C;
                else if (f7 == 7'b0000000 && f3 == 3'b010) code = SLT_C;
`ifdef ALU_CTRL_MUL_EN
                else if (is_mul) code = MUL_C;
`endif
                else illegal = 1'b1;
            end
            default: illegal = f3 != 3'b000;
        endcase
    end
    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (accept) begin
            ctrl_d    = code;
            valid_d   = 1'b1;
            illegal_d = illegal;
        end
`ifdef ALU_CTRL_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == MULWAIT) begin
            if (cnt_q == 4'd0) begin
                state_d = IDLE;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (accept && is_mul && MUL_LAT > 1) begin
            // Completion strobe deferred until the countdown expires.
            valid_d = 1'b0;
            state_d = MULWAIT;
            cnt_d   = 4'(MUL_LAT - 2);
        end
        // Flush wins over a same-edge accept or MUL completion.
        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            valid_d = 1'b0;
        end
`endif
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q    <= ADD_C;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
`ifdef ALU_CTRL_MUL_EN
            state_q   <= state_d;
            cnt_q     <= cnt_d;
`endif
        end
    end
    assign bus.ready_o   = ready;
    assign bus.ALUCtrl_o = ctrl_q;
    assign bus.valid_o   = valid_q;
    assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: directed self-checking bench for alu_ctrl_unit.
module tb_alu_ctrl_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    alu_ctrl_unit_if bus();
    alu_ctrl_unit_if bus4();
    alu_ctrl_unit #(.MUL_LAT(3)) dut  (.clk_i(clk), .rst_i(rst_n), .bus(bus));
    alu_ctrl_unit #(.MUL_LAT(4)) dut4 (.clk_i(clk), .rst_i(rst_n), .bus(bus4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [9:0] f);
        bus.valid_i = v;
        bus.ALUOp_i = op;
        bus.funct_i = f;
    endtask

    task automatic test_reset;
        bus.flush_i = 1'b0;
        drive(1'b0, 2'b00, 10'd0);
        bus4.valid_i = 1'b0;
        bus4.ALUOp_i = 2'b00;
        bus4.funct_i = 10'd0;
        bus4.flush_i = 1'b0;
        tick;
        checks++; if (bus.ALUCtrl_o !== 3'b010) begin failures++; $display("FAIL por_ctrl got=%b exp=010", bus.ALUCtrl_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL por_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.illegal_o !== 1'b0) begin failures++; $display("FAIL por_illegal got=%b exp=0", bus.illegal_o); end
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL por_ready got=%b exp=1", bus.ready_o); end
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 10'd0);
        tick;
        checks++; if (bus.ALUCtrl_o !== 3'b110 || bus.valid_o !== 1'b1) begin failures++; $display("FAIL pre_reset_sub got=%b/%b exp=110/1", bus.ALUCtrl_o, bus.valid_o); end
        drive(1'b0, 2'b00, 10'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ALUCtrl_o !== 3'b010) begin failures++; $display("FAIL async_reset_ctrl got=%b exp=010", bus.ALUCtrl_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b exp=1", bus.ready_o); end
        #1 rst_n = 1'b1;
        tick;
    endtask

    task automatic test_rtype_back_to_back;
        logic [1:0] ops [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
        logic [9:0] fns [8] = '{10'b0000000_111, 10'b0000000_110, 10'b0100000_000, 10'b0000000_000,
                                10'b0000000_000, 10'b0100000_000, 10'b1111111_111, 10'b0000000_010};
        logic [2:0] exp [8] = '{3'b000, 3'b001, 3'b110, 3'b010, 3'b110, 3'b010, 3'b010, 3'b111};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], fns[i]);
            tick;
            checks++; if (bus.valid_o !== 1'b1 || bus.illegal_o !== 1'b0 || bus.ALUCtrl_o !== exp[i]) begin
                failures++; $display("FAIL b2b[%0d] got ctrl=%b v=%b ill=%b exp ctrl=%b v=1 ill=0", i, bus.ALUCtrl_o, bus.valid_o, bus.illegal_o, exp[i]);
            end
        end
        drive(1'b0, 2'b10, 10'b0000000_111);
        tick;
        checks++; if (bus.valid_o !== 1'b0 || bus.ALUCtrl_o !== 3'b111) begin failures++; $display("FAIL idle_hold got v=%b ctrl=%b exp v=0 ctrl=111", bus.valid_o, bus.ALUCtrl_o); end
    endtask

    task automatic test_illegal;
        logic [1:0] ops [4] = '{2'b10, 2'b10, 2'b10, 2'b11};
        logic [9:0] fns [4] = '{10'b0000000_111, 10'b0100000_111, 10'b0000000_110, 10'b0000000_001};
        logic [2:0] exp [4] = '{3'b000, 3'b010, 3'b001, 3'b010};
        logic       ill [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], fns[i]);
            tick;
            checks++; if (bus.valid_o !== 1'b1 || bus.illegal_o !== ill[i] || bus.ALUCtrl_o !== exp[i]) begin
                failures++; $display("FAIL illegal[%0d] got ctrl=%b v=%b ill=%b exp ctrl=%b v=1 ill=%b", i, bus.ALUCtrl_o, bus.valid_o, bus.illegal_o, exp[i], ill[i]);
            end
        end
        drive(1'b0, 2'b00, 10'd0);
        tick;
        checks++; if (bus.illegal_o !== 1'b0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL illegal_pulse got ill=%b v=%b exp 0/0", bus.illegal_o, bus.valid_o); end
    endtask

    task automatic test_flush_accept;
        drive(1'b1, 2'b10, 10'b0000000_111);
        bus.flush_i = 1'b1;
        tick;
        checks++; if (bus.valid_o !== 1'b0 || bus.ALUCtrl_o !== 3'b010) begin failures++; $display("FAIL flush_accept got v=%b ctrl=%b exp v=0 ctrl=010", bus.valid_o, bus.ALUCtrl_o); end
        bus.flush_i = 1'b0;
        drive(1'b0, 2'b00, 10'd0);
        tick;
    endtask

`ifdef ALU_CTRL_MUL_EN
    task automatic test_mul_latency;
        drive(1'b1, 2'b10, 10'b0000001_000);
        tick;
        checks++; if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.ALUCtrl_o !== 3'b011) begin failures++; $display("FAIL mul_e0 got r=%b v=%b ctrl=%b exp r=0 v=0 ctrl=011", bus.ready_o, bus.valid_o, bus.ALUCtrl_o); end
        drive(1'b1, 2'b00, 10'd0);
        tick;
        checks++; if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL mul_e1 got r=%b v=%b exp r=0 v=0", bus.ready_o, bus.valid_o); end
        tick;
        checks++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b1 || bus.illegal_o !== 1'b0 || bus.ALUCtrl_o !== 3'b011) begin failures++; $display("FAIL mul_done got r=%b v=%b ill=%b ctrl=%b exp r=1 v=1 ill=0 ctrl=011", bus.ready_o, bus.valid_o, bus.illegal_o, bus.ALUCtrl_o); end
        tick;
        checks++; if (bus.valid_o !== 1'b1 || bus.ALUCtrl_o !== 3'b010) begin failures++; $display("FAIL mul_next_add got v=%b ctrl=%b exp v=1 ctrl=010", bus.valid_o, bus.ALUCtrl_o); end
        drive(1'b0, 2'b00, 10'd0);
        tick;
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL mul_after got v=%b exp 0", bus.valid_o); end
    endtask

    task automatic test_mul_lat4;
        bus4.valid_i = 1'b1;
        bus4.ALUOp_i = 2'b10;
        bus4.funct_i = 10'b0000001_000;
        for (int i = 0; i < 4; i++) begin
            tick;
            bus4.valid_i = 1'b0;
            checks++; if (bus4.valid_o !== (i == 3) || bus4.ready_o !== (i == 3)) begin failures++; $display("FAIL lat4_e%0d got v=%b r=%b exp v=%b r=%b", i, bus4.valid_o, bus4.ready_o, i == 3, i == 3); end
        end
        tick;
    endtask

    task automatic test_flush_mul;
        bus4.valid_i = 1'b1;
        bus4.ALUOp_i = 2'b10;
        bus4.funct_i = 10'b0000001_000;
        tick;
        bus4.valid_i = 1'b0;
        checks++; if (bus4.ready_o !== 1'b0 || bus4.ALUCtrl_o !== 3'b011 || bus4.valid_o !== 1'b0) begin failures++; $display("FAIL flush_e0 got r=%b ctrl=%b v=%b exp r=0 ctrl=011 v=0", bus4.ready_o, bus4.ALUCtrl_o, bus4.valid_o); end
        tick;
        checks++; if (bus4.ready_o !== 1'b0 || bus4.valid_o !== 1'b0) begin failures++; $display("FAIL flush_e1 got r=%b v=%b exp r=0 v=0", bus4.ready_o, bus4.valid_o); end
        bus4.flush_i = 1'b1;
        tick;
        bus4.flush_i = 1'b0;
        checks++; if (bus4.ready_o !== 1'b1 || bus4.valid_o !== 1'b0 || bus4.ALUCtrl_o !== 3'b011) begin failures++; $display("FAIL flush_e2 got r=%b v=%b ctrl=%b exp r=1 v=0 ctrl=011", bus4.ready_o, bus4.valid_o, bus4.ALUCtrl_o); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (bus4.valid_o !== 1'b0 || bus4.ready_o !== 1'b1) begin failures++; $display("FAIL flush_after[%0d] got v=%b r=%b exp v=0 r=1", i, bus4.valid_o, bus4.ready_o); end
        end
    endtask

    task automatic test_reset_mid_mul;
        drive(1'b1, 2'b10, 10'b0000001_000);
        tick;
        drive(1'b0, 2'b00, 10'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ready_o !== 1'b1 || bus.ALUCtrl_o !== 3'b010) begin failures++; $display("FAIL rst_mul got r=%b ctrl=%b exp r=1 ctrl=010", bus.ready_o, bus.ALUCtrl_o); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_mul_after[%0d] got v=%b exp 0", i, bus.valid_o); end
        end
    endtask
`else
    task automatic test_config_off;
        drive(1'b1, 2'b10, 10'b0000001_000);
        tick;
        checks++; if (bus.valid_o !== 1'b1 || bus.illegal_o !== 1'b1 || bus.ALUCtrl_o !== 3'b010 || bus.ready_o !== 1'b1) begin
            failures++; $display("FAIL mul_off got v=%b ill=%b ctrl=%b r=%b exp v=1 ill=1 ctrl=010 r=1", bus.valid_o, bus.illegal_o, bus.ALUCtrl_o, bus.ready_o);
        end
        drive(1'b1, 2'b10, 10'b0000000_111);
        tick;
        checks++; if (bus.valid_o !== 1'b1 || bus.illegal_o !== 1'b0 || bus.ALUCtrl_o !== 3'b000 || bus.ready_o !== 1'b1) begin
            failures++; $display("FAIL mul_off_next got v=%b ill=%b ctrl=%b r=%b exp v=1 ill=0 ctrl=000 r=1", bus.valid_o, bus.illegal_o, bus.ALUCtrl_o, bus.ready_o);
        end
        drive(1'b0, 2'b00, 10'd0);
        tick;
        checks++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin failures++; $display("FAIL mul_off_idle got v=%b r=%b exp v=0 r=1", bus.valid_o, bus.ready_o); end
    endtask
`endif

    initial begin
        test_reset;
        test_rtype_back_to_back;
        test_illegal;
        test_flush_accept;
`ifdef ALU_CTRL_MUL_EN
        test_mul_latency;
        test_mul_lat4;
        test_flush_mul;
        test_reset_mid_mul;
`else
        test_config_off;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
